// File: rtl/ntt_job_scheduler.sv
// ntt_job_scheduler: queues host NTT/INTT/PWM jobs and sequences them one at a time onto the polytop core.
// Optional watchdog: define SCHED_TIMEOUT_EN to abort a run that exceeds TIMEOUT cycles.
module ntt_job_scheduler #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned TIMEOUT = 4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_opcode,
    input  logic             cmd_mode,
    input  logic             cmd_offset,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [1:0]       core_opcode,
    output logic             core_mode,
    output logic             core_offset,
    output logic             core_start,
    input  logic             core_finish,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_status,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             busy
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned CMD_W  = TAG_W + 4;
    localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);

    localparam logic [1:0] OP_RSVD   = 2'b11;
    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_REJECT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]  count_q, count_d;
    logic [CMD_W-1:0]   mem_q [DEPTH];
    logic [1:0]         opcode_q, opcode_d;
    logic               mode_q, mode_d;
    logic               offset_q, offset_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [1:0]         status_q, status_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               start_q, start_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;

    logic               push;
    logic               pop;
    logic [CMD_W-1:0]   head;
    logic [CNT_W-1:0]   cnt_inc;

    // Ready is held low while reset is asserted so no command is taken before the FIFO is live.
    assign cmd_ready = rst && (count_q != FCNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

`ifndef SCHED_TIMEOUT_EN
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    // Next-state, FIFO bookkeeping and job latching.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        mode_d   = mode_q;
        offset_d = offset_q;
        tag_d    = tag_q;
        status_d = status_q;
        cycles_d = cycles_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop   = 1'b1;
                    tag_d = head[TAG_W-1:0];
                    if (head[CMD_W-1:CMD_W-2] == OP_RSVD) begin
                        status_d = ST_REJECT;
                        cycles_d = '0;
                        state_d  = S_RESP;
                    end else begin
                        opcode_d = head[CMD_W-1:CMD_W-2];
                        mode_d   = head[TAG_W+1];
                        offset_d = head[TAG_W];
                        cnt_d    = CNT_W'(1);
                        state_d  = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = cnt_inc;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (core_finish) begin
                    status_d = ST_OK;
                    cycles_d = cnt_q;
                    gap_d    = '0;
                    state_d  = S_DRAIN;
`ifdef SCHED_TIMEOUT_EN
                end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
                    status_d = 2'b01;
                    cycles_d = CNT_W'(TIMEOUT);
                    gap_d    = '0;
                    state_d  = S_DRAIN;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DRAIN: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = S_RESP;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q + FCNT_W'(push) - FCNT_W'(pop);
        start_d     = (state_d == S_LAUNCH);
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            opcode_q    <= '0;
            mode_q      <= 1'b0;
            offset_q    <= 1'b0;
            tag_q       <= '0;
            status_q    <= '0;
            cycles_q    <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            opcode_q    <= opcode_d;
            mode_q      <= mode_d;
            offset_q    <= offset_d;
            tag_q       <= tag_d;
            status_q    <= status_d;
            cycles_q    <= cycles_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Command storage, packed as {opcode, mode, offset, tag}.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {cmd_opcode, cmd_mode, cmd_offset, cmd_tag};
        end
    end

    assign core_opcode = opcode_q;
    assign core_mode   = mode_q;
    assign core_offset = offset_q;
    assign core_start  = start_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_tag     = tag_q;
    assign rsp_status  = status_q;
    assign rsp_cycles  = cycles_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Scoreboard bench for ntt_job_scheduler: a core model answers start pulses after a per-job run length.
// Build with SCHED_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT=50).
module tb_ntt_job_scheduler;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned GAP_CYC = 4;
`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 50;
`else
    localparam int unsigned TIMEOUT = 4000;
`endif

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [1:0]       status;
        logic [CNT_W-1:0] cycles;
    } rsp_t;

    typedef struct packed {
        logic [1:0]  op;
        logic        mode;
        logic        off;
        int unsigned run;
    } job_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_opcode;
    logic             cmd_mode;
    logic             cmd_offset;
    logic [TAG_W-1:0] cmd_tag;
    logic [1:0]       core_opcode;
    logic             core_mode;
    logic             core_offset;
    logic             core_start;
    logic             core_finish;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_status;
    logic [CNT_W-1:0] rsp_cycles;
    logic             busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    int unsigned n_starts = 0;
    int unsigned n_rsp_cyc = 0;
    int unsigned inject_cnt = 0;

    rsp_t exp_q[$];
    job_t job_q[$];

    ntt_job_scheduler #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_mode(cmd_mode), .cmd_offset(cmd_offset), .cmd_tag(cmd_tag),
        .core_opcode(core_opcode), .core_mode(core_mode), .core_offset(core_offset),
        .core_start(core_start), .core_finish(core_finish),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_status(rsp_status), .rsp_cycles(rsp_cycles), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Core model and response monitor, sampling mid-cycle.
    job_t        cur;
    logic        fin_pending = 1'b0;
    int unsigned fin_at = 0;
    logic        prev_start = 1'b0;
    int unsigned inject_seen = 0;
    rsp_t        e;

    always @(negedge clk) begin
        if (!rst) begin
            fin_pending = 1'b0;
            core_finish = 1'b0;
            prev_start  = 1'b0;
            exp_q.delete();
            job_q.delete();
        end else begin
            core_finish = 1'b0;
            if (inject_seen != inject_cnt) begin
                core_finish = 1'b1;
                inject_seen = inject_cnt;
            end
            if (fin_pending && cyc == fin_at) begin
                core_finish = 1'b1;
                fin_pending = 1'b0;
                check_eq("cfg_stable", {30'd0, core_opcode} << 2 | {30'd0, core_mode, core_offset},
                         {30'd0, cur.op} << 2 | {30'd0, cur.mode, cur.off});
            end
            if (core_start) begin
                n_starts++;
                check_eq("start_width", 32'(prev_start), 32'd0);
                if (job_q.size() == 0) begin
                    check_eq("start_unexpected", 32'(core_start), 32'd0);
                end else begin
                    cur = job_q.pop_front();
                    check_eq("core_opcode", 32'(core_opcode), 32'(cur.op));
                    check_eq("core_mode_off", 32'({core_mode, core_offset}), 32'({cur.mode, cur.off}));
                    if (cur.run != 0) begin
                        fin_pending = 1'b1;
                        fin_at      = cyc + cur.run;
                    end
                end
            end
            prev_start = core_start;
            if (rsp_valid) n_rsp_cyc++;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                    check_eq("rsp_status", 32'(rsp_status), 32'(e.status));
                    check_eq("rsp_cycles", 32'(rsp_cycles), 32'(e.cycles));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge with cmd_valid dropped.
    task automatic send(input logic [1:0] op, input logic md, input logic off,
                        input logic [TAG_W-1:0] tag, input int unsigned run);
        int unsigned waited = 0;
        rsp_t r;
        job_t j;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_mode = md; cmd_offset = off; cmd_tag = tag;
        while (!cmd_ready && waited < 2000) begin
            @(posedge clk); #1; waited++;
        end
        if (!cmd_ready) begin
            check_eq("cmd_accept_wait", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        acc_cyc  = cyc;
        r.tag    = tag;
        if (op == 2'b11) begin
            r.status = 2'b10;
            r.cycles = '0;
        end else if (run == 0) begin
            r.status = 2'b01;
            r.cycles = CNT_W'(TIMEOUT);
        end else begin
            r.status = 2'b00;
            r.cycles = CNT_W'(run + 1);
        end
        exp_q.push_back(r);
        if (op != 2'b11) begin
            j.op = op; j.mode = md; j.off = off; j.run = run;
            job_q.push_back(j);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp_valid(input int unsigned limit);
        int unsigned n = 0;
        while (!rsp_valid && n < limit) begin
            @(posedge clk); #1; n++;
        end
        if (!rsp_valid) check_eq("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic drain_all(input int unsigned limit);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk); #1; n++;
        end
        check_eq("scoreboard_empty", exp_q.size(), 32'd0);
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int unsigned n;
        int unsigned rsp_before;
        rst = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_mode = 1'b0;
        cmd_offset = 1'b0; cmd_tag = '0; rsp_ready = 1'b1;

        // Reset state
        #23;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_outputs", 32'({busy, rsp_valid, core_start, core_opcode, rsp_status}), 32'd0);
        check_eq("rst_rsp_cycles", 32'(rsp_cycles), 32'd0);
        @(negedge clk); rst = 1'b1; #1;
        check_eq("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // Single NTT, tag 3, 200-cycle run: latency counted inclusively from accept cycle to first rsp_valid cycle
        send(2'b00, 1'b0, 1'b1, 4'd3, 200);
        n = 0;
        while (!rsp_valid && n < 400) begin
            @(posedge clk); #1; n++;
        end
        check_eq("latency", cyc - acc_cyc + 1, 2 + 201 + GAP_CYC + 1);
        drain_all(50);
        check_eq("starts_single", n_starts, 32'd1);

        // Response backpressure with FIFO filling behind it; reserved opcode in the queue
        rsp_ready = 1'b0;
        send(2'b01, 1'b1, 1'b0, 4'd1, 40);
        wait_rsp_valid(200);
        n = n_starts;
        send(2'b11, 1'b1, 1'b1, 4'd7, 0);
        send(2'b01, 1'b1, 1'b1, 4'd4, 30);
        send(2'b10, 1'b0, 1'b1, 4'd5, 20);
        send(2'b00, 1'b1, 1'b0, 4'd6, 15);
        check_eq("full_cmd_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check_eq("stall_rsp", 32'({rsp_valid, rsp_tag, rsp_status}), 32'({1'b1, 4'd1, 2'b00}));
            check_eq("stall_cycles", 32'(rsp_cycles), 32'd41);
            @(posedge clk); #1;
        end
        check_eq("stall_no_start", n_starts, n);
        rsp_ready = 1'b1;
        send(2'b00, 1'b0, 1'b0, 4'd8, 25);
        drain_all(2000);
        check_eq("starts_total", n_starts, 32'd6);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of a run drops everything
        send(2'b01, 1'b1, 1'b1, 4'd9, 100);
        send(2'b00, 1'b0, 1'b0, 4'd10, 50);
        idle(30);
        check_eq("run_busy", 32'(busy), 32'd1);
        @(posedge clk); #3;
        rst = 1'b0; #1;
        check_eq("async_clear", 32'({busy, rsp_valid, core_start, core_opcode, core_mode, core_offset}), 32'd0);
        check_eq("async_rsp", 32'({rsp_tag, rsp_status, rsp_cycles}), 32'd0);
        check_eq("async_cmd_ready", 32'(cmd_ready), 32'd0);
        idle(2);
        @(negedge clk); rst = 1'b1; #1;
        check_eq("rerel_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_before = n_rsp_cyc;
        @(posedge clk); #1;
        idle(200);
        check_eq("no_rsp_after_rst", n_rsp_cyc, rsp_before);
        check_eq("idle_after_rst", 32'(busy), 32'd0);

`ifdef SCHED_TIMEOUT_EN
        // Watchdog: core never finishes
        send(2'b00, 1'b1, 1'b0, 4'd11, 0);
        drain_all(300);
`endif

        // Finish pulse outside RUN must be ignored
        rsp_before = n_rsp_cyc;
        inject_cnt++;
        idle(20);
        check_eq("stray_finish_rsp", n_rsp_cyc, rsp_before);
        check_eq("stray_finish_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got cycle %0d required finish earlier", cyc);
        $fatal(1);
    end

endmodule
